// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status going in, register control strobes coming out.
// The slave modport is the controller; the master modport is the pipeline side.
interface hazard_ctrl_if;
    logic [3:0]  SrcReg1_ID;
    logic [3:0]  SrcReg2_ID;
    logic        Src1Used_ID;
    logic        Src2Used_ID;
    logic        MemRead_EX;
    logic [3:0]  DstReg_EX;
    logic        BranchTaken_ID;
    logic        IMiss;
    logic        DMiss;
    logic        Halt_ID;
    logic        Halt_WB;

    logic        stall_PC;
    logic        stall_IFID;
    logic        flush_IFID;
    logic        nop_IDEX;
    logic        stall_IDEX;
    logic        stall_EXMEM;
    logic        stall_MEMWB;
    logic [1:0]  hz_state;
    logic [15:0] stall_cnt;

    modport master (
        output SrcReg1_ID, SrcReg2_ID, Src1Used_ID, Src2Used_ID, MemRead_EX, DstReg_EX,
        output BranchTaken_ID, IMiss, DMiss, Halt_ID, Halt_WB,
        input  stall_PC, stall_IFID, flush_IFID, nop_IDEX, stall_IDEX, stall_EXMEM,
        input  stall_MEMWB, hz_state, stall_cnt
    );

    modport slave (
        input  SrcReg1_ID, SrcReg2_ID, Src1Used_ID, Src2Used_ID, MemRead_EX, DstReg_EX,
        input  BranchTaken_ID, IMiss, DMiss, Halt_ID, Halt_WB,
        output stall_PC, stall_IFID, flush_IFID, nop_IDEX, stall_IDEX, stall_EXMEM,
        output stall_MEMWB, hz_state, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch redirects, cache-miss freezes and halt
// drain, with a saturating stall-cycle counter for performance runs.
module hazard_ctrl (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDmiss  = 2'd1,
        StDrain  = 2'd2,
        StHalted = 2'd3
    } state_e;

    state_e      state_q, state_d;
    state_e      ret_q, ret_d;
    state_e      eff_state;
    logic [15:0] cnt_q, cnt_d;
    logic        lu;
    logic        freeze;
    logic        s_pc, s_ifid, f_ifid, n_idex, s_idex, s_exmem, s_memwb;

    assign lu = bus.MemRead_EX & (bus.DstReg_EX != 4'd0) &
                ((bus.Src1Used_ID & (bus.SrcReg1_ID == bus.DstReg_EX)) |
                 (bus.Src2Used_ID & (bus.SrcReg2_ID == bus.DstReg_EX)));

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        freeze    = 1'b0;
        s_pc      = 1'b0;
        s_ifid    = 1'b0;
        f_ifid    = 1'b0;
        n_idex    = 1'b0;
        s_idex    = 1'b0;
        s_exmem   = 1'b0;
        s_memwb   = 1'b0;
        // The cycle a D-miss ends, behave as the state we froze from.
        eff_state = state_q;
        if (state_q == StDmiss && !bus.DMiss) begin
            eff_state = ret_q;
        end

        if (!rst) begin
            case (eff_state)
                StRun: begin
                    if (bus.DMiss) begin
                        freeze  = 1'b1;
                        ret_d   = StRun;
                        state_d = StDmiss;
                    end else begin
                        state_d = StRun;
                        if (lu || (bus.BranchTaken_ID && bus.IMiss)) begin
                            s_pc   = 1'b1;
                            s_ifid = 1'b1;
                            n_idex = 1'b1;
                        end else if (bus.BranchTaken_ID) begin
                            f_ifid = 1'b1;
                        end else if (bus.IMiss) begin
                            s_pc   = 1'b1;
                            f_ifid = 1'b1;
                        end else if (bus.Halt_ID) begin
                            s_pc    = 1'b1;
                            f_ifid  = 1'b1;
                            state_d = StDrain;
                        end
                    end
                end
                StDmiss: begin
                    freeze = 1'b1;
                end
                StDrain: begin
                    if (bus.DMiss) begin
                        freeze  = 1'b1;
                        ret_d   = StDrain;
                        state_d = StDmiss;
                    end else begin
                        s_pc    = 1'b1;
                        f_ifid  = 1'b1;
                        state_d = bus.Halt_WB ? StHalted : StDrain;
                    end
                end
                StHalted: begin
                    freeze = 1'b1;
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end

        // A freeze overrides any bubble or flush picked above.
        if (freeze) begin
            s_pc    = 1'b1;
            s_ifid  = 1'b1;
            s_idex  = 1'b1;
            s_exmem = 1'b1;
            s_memwb = 1'b1;
            f_ifid  = 1'b0;
            n_idex  = 1'b0;
        end

        cnt_d = cnt_q;
        if (s_pc && state_q != StHalted && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            ret_q   <= StRun;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.stall_PC    = s_pc;
    assign bus.stall_IFID  = s_ifid;
    assign bus.flush_IFID  = f_ifid;
    assign bus.nop_IDEX    = n_idex;
    assign bus.stall_IDEX  = s_idex;
    assign bus.stall_EXMEM = s_exmem;
    assign bus.stall_MEMWB = s_memwb;
    assign bus.hz_state    = state_q;
    assign bus.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a RUN-priority vector table plus hand-written
// multi-cycle sequences for D-miss freeze, halt drain, reset and counter saturation.
module tb_hazard_ctrl;

    typedef struct {
        logic [3:0] s1;
        logic [3:0] s2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [3:0] dst;
        logic       br;
        logic       im;
        logic       dm;
        logic       hid;
        logic       hwb;
        logic [6:0] exp;  // {stall_PC, stall_IFID, flush_IFID, nop_IDEX, stall_IDEX, EXMEM, MEMWB}
    } vec_t;

    localparam logic [6:0] OutNone   = 7'b0000000;
    localparam logic [6:0] OutBubble = 7'b1101000;
    localparam logic [6:0] OutFlush  = 7'b0010000;
    localparam logic [6:0] OutHold   = 7'b1010000;
    localparam logic [6:0] OutFreeze = 7'b1100111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    hazard_ctrl_if bus ();

    hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] outs;
    assign outs = {bus.stall_PC, bus.stall_IFID, bus.flush_IFID, bus.nop_IDEX,
                   bus.stall_IDEX, bus.stall_EXMEM, bus.stall_MEMWB};

    function automatic vec_t mk(input logic [3:0] s1, input logic [3:0] s2, input logic u1,
                                input logic u2, input logic mr, input logic [3:0] dst,
                                input logic br, input logic im, input logic dm, input logic hid,
                                input logic hwb, input logic [6:0] exp);
        vec_t v;
        v.s1 = s1; v.s2 = s2; v.u1 = u1; v.u2 = u2; v.mr = mr; v.dst = dst;
        v.br = br; v.im = im; v.dm = dm; v.hid = hid; v.hwb = hwb; v.exp = exp;
        return v;
    endfunction

    task automatic set_in(input vec_t v);
        bus.SrcReg1_ID     = v.s1;
        bus.SrcReg2_ID     = v.s2;
        bus.Src1Used_ID    = v.u1;
        bus.Src2Used_ID    = v.u2;
        bus.MemRead_EX     = v.mr;
        bus.DstReg_EX      = v.dst;
        bus.BranchTaken_ID = v.br;
        bus.IMiss          = v.im;
        bus.DMiss          = v.dm;
        bus.Halt_ID        = v.hid;
        bus.Halt_WB        = v.hwb;
    endtask

    task automatic chk_out(input string name, input logic [6:0] exp);
        n_cmp++;
        if (outs !== exp) begin
            n_bad++;
            $display("FAIL %s: outputs got %b want %b", name, outs, exp);
        end
    endtask

    task automatic chk_val(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    vec_t zero;
    vec_t vecs[14];
    vec_t v;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        v = zero;
        v.dm = 1'b1;
        v.br = 1'b1;
        set_in(v);  // outputs must stay low during reset whatever the inputs
        #2;
        chk_out("reset_outs", OutNone);
        chk_val("reset_state", {14'd0, bus.hz_state}, 16'd0);
        chk_val("reset_cnt", bus.stall_cnt, 16'd0);
        set_in(zero);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        zero = mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OutNone);
        //            s1     s2     u1    u2    mr    dst    br    im    dm    hid   hwb
        vecs[0]  = mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OutNone);
        vecs[1]  = mk(4'd1, 4'd3, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OutBubble);
        vecs[2]  = mk(4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OutNone);
        vecs[3]  = mk(4'd5, 4'd2, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OutNone);
        vecs[4]  = mk(4'd5, 4'd2, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OutBubble);
        vecs[5]  = mk(4'd5, 4'd5, 1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OutNone);
        vecs[6]  = mk(4'd7, 4'd0, 1'b1, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OutBubble);
        vecs[7]  = mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OutBubble);
        vecs[8]  = mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OutFlush);
        vecs[9]  = mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, OutHold);
        vecs[10] = mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, OutHold);
        vecs[11] = mk(4'd4, 4'd0, 1'b1, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, OutFreeze);
        vecs[12] = mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OutFlush);
        vecs[13] = mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, OutHold);

        set_in(zero);
        do_reset();

        // RUN priority table; vec 11 enters DMISS, vec 12 is the cycle it releases.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            set_in(vecs[i]);
            #2;
            chk_out($sformatf("vec%0d", i), vecs[i].exp);
        end
        @(negedge clk);
        set_in(zero);
        chk_val("halt_id_enters_drain", {14'd0, bus.hz_state}, 16'd2);

        // Load-use: one bubble, then release.
        do_reset();
        v = zero; v.mr = 1'b1; v.dst = 4'd3; v.s2 = 4'd3; v.u2 = 1'b1;
        set_in(v);
        #2 chk_out("lu_bubble", OutBubble);
        @(negedge clk);
        v.mr = 1'b0;
        set_in(v);
        #2 chk_out("lu_release", OutNone);
        chk_val("lu_cnt", bus.stall_cnt, 16'd1);
        v.mr = 1'b1; v.dst = 4'd0; v.s2 = 4'd0;
        set_in(v);
        #2 chk_out("lu_r0", OutNone);

        // D-cache freeze for three cycles from RUN.
        do_reset();
        v = zero; v.dm = 1'b1; v.br = 1'b1;
        set_in(v);
        #2 chk_out("dm_c1", OutFreeze);
        chk_val("dm_c1_state", {14'd0, bus.hz_state}, 16'd0);
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            #2 chk_out($sformatf("dm_c%0d", c), OutFreeze);
            chk_val($sformatf("dm_c%0d_state", c), {14'd0, bus.hz_state}, 16'd1);
        end
        @(negedge clk);
        v.dm = 1'b0;
        set_in(v);
        #2 chk_out("dm_release", OutFlush);
        chk_val("dm_cnt", bus.stall_cnt, 16'd3);
        @(negedge clk);
        chk_val("dm_back_run", {14'd0, bus.hz_state}, 16'd0);

        // Taken branch held under an I-miss.
        do_reset();
        v = zero; v.br = 1'b1; v.im = 1'b1;
        set_in(v);
        for (int c = 0; c < 2; c++) begin
            #2 chk_out($sformatf("br_imiss%0d", c), OutBubble);
            @(negedge clk);
        end
        v.im = 1'b0;
        set_in(v);
        #2 chk_out("br_after_imiss", OutFlush);

        // Halt, three drain cycles, then halted with the counter frozen.
        do_reset();
        v = zero; v.hid = 1'b1;
        set_in(v);
        #2 chk_out("halt_id", OutHold);
        @(negedge clk);
        set_in(zero);
        #2 chk_out("drain1", OutHold);
        chk_val("drain_state", {14'd0, bus.hz_state}, 16'd2);
        repeat (2) @(negedge clk);
        v = zero; v.hwb = 1'b1;
        set_in(v);
        #2 chk_out("drain_hwb", OutHold);
        @(negedge clk);
        set_in(zero);
        #2 chk_out("halted", OutFreeze);
        chk_val("halted_state", {14'd0, bus.hz_state}, 16'd3);
        chk_val("halted_cnt", bus.stall_cnt, 16'd4);
        repeat (3) @(negedge clk);
        chk_val("halted_cnt_frozen", bus.stall_cnt, 16'd4);
        chk_val("halted_stays", {14'd0, bus.hz_state}, 16'd3);

        // D-miss during drain; Halt_WB seen only once the miss clears.
        do_reset();
        v = zero; v.hid = 1'b1;
        set_in(v);
        @(negedge clk);
        v = zero; v.dm = 1'b1;
        set_in(v);
        #2 chk_out("drain_dm", OutFreeze);
        @(negedge clk);
        v.hwb = 1'b1;
        set_in(v);
        #2 chk_out("drain_dm_hwb", OutFreeze);
        @(negedge clk);
        chk_val("drain_dm_stays", {14'd0, bus.hz_state}, 16'd1);
        v.dm = 1'b0;
        set_in(v);
        #2 chk_out("drain_dm_release", OutHold);
        @(negedge clk);
        set_in(zero);
        chk_val("drain_dm_halted", {14'd0, bus.hz_state}, 16'd3);

        // Asynchronous reset mid-DMISS.
        do_reset();
        v = zero; v.dm = 1'b1;
        set_in(v);
        @(negedge clk);
        chk_val("pre_rst_state", {14'd0, bus.hz_state}, 16'd1);
        #2 rst = 1'b1;
        #1 chk_out("async_rst_outs", OutNone);
        chk_val("async_rst_state", {14'd0, bus.hz_state}, 16'd0);
        chk_val("async_rst_cnt", bus.stall_cnt, 16'd0);
        set_in(zero);
        @(negedge clk);
        rst = 1'b0;

        // Counter saturation under a long I-miss.
        do_reset();
        v = zero; v.im = 1'b1;
        set_in(v);
        repeat (65534) @(posedge clk);
        #1 chk_val("cnt_fffe", bus.stall_cnt, 16'hFFFE);
        repeat (4466) @(posedge clk);
        #1 chk_val("cnt_sat", bus.stall_cnt, 16'hFFFF);
        repeat (5) @(posedge clk);
        #1 chk_val("cnt_sat_hold", bus.stall_cnt, 16'hFFFF);
        set_in(zero);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller: the producer of the `stall`/`nop` controls consumed by the ID/EX register, plus the matching controls for PC, IF/ID, EX/MEM and MEM/WB. It detects load-use hazards, taken-branch redirects, instruction- and data-cache misses, and halt. A registered FSM tracks multi-cycle conditions (D-cache freeze, halt drain, halted). A saturating counter records stall cycles for performance runs.

## Interface
Parameters: none.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- SrcReg1_ID, SrcReg2_ID  in  4  source registers of the instruction in ID
- Src1Used_ID, Src2Used_ID  in  1  the corresponding source is actually read
- MemRead_EX  in  1  instruction in EX is a load (ID/EX `to_Mem[0]`)
- DstReg_EX  in  4  destination register of the instruction in EX
- BranchTaken_ID  in  1  branch in ID resolved taken
- IMiss  in  1  I-cache busy; held high until the fill completes
- DMiss  in  1  D-cache busy; held high until the fill completes
- Halt_ID  in  1  HLT instruction in ID
- Halt_WB  in  1  HLT instruction in WB
- stall_PC  out  1  hold PC
- stall_IFID  out  1  hold IF/ID
- flush_IFID  out  1  load a bubble into IF/ID
- nop_IDEX  out  1  load a bubble into ID/EX
- stall_IDEX  out  1  hold ID/EX (drives the ID/EX `stall` input)
- stall_EXMEM, stall_MEMWB  out  1  hold EX/MEM and MEM/WB
- hz_state  out  2  FSM state: RUN=0, DMISS=1, DRAIN=2, HALTED=3
- stall_cnt  out  16  saturating count of stall cycles

## Operation
- Outputs are combinational from the registered state and current inputs. The state, return register and counter are registered.
- **Load-use condition (lu):** `MemRead_EX & DstReg_EX!=0 & ((Src1Used_ID & SrcReg1_ID==DstReg_EX) | (Src2Used_ID & SrcReg2_ID==DstReg_EX))`.
- **RUN** — evaluate the following in priority order; any output not listed is 0:
  1. DMiss: all five stall outputs =1. Save ret=RUN. Next state DMISS.
  2. lu: stall_PC=stall_IFID=nop_IDEX=1. BranchTaken_ID is ignored this cycle.
  3. BranchTaken_ID & IMiss: stall_PC=stall_IFID=nop_IDEX=1. The branch is held in ID until the miss ends.
  4. BranchTaken_ID: flush_IFID=1. The PC loads the target.
  5. IMiss: stall_PC=flush_IFID=1.
  6. Halt_ID: stall_PC=flush_IFID=1. Next state DRAIN.
- **DMISS:** all five stalls =1; flush_IFID=nop_IDEX=0.
  - While DMiss=1, stay in DMISS.
  - On DMiss=0, return to ret. That same cycle, evaluate outputs as in state ret.
- **DRAIN:** stall_PC=flush_IFID=1.
  - DMiss=1 → freeze as in DMISS, with ret=DRAIN.
  - Halt_WB=1 → next state HALTED.
- **HALTED:** all five stalls =1; flush=nop=0. Only rst exits.
- **stall_cnt:** increments when stall_PC=1 and state≠HALTED. Saturates at 16'hFFFF.

## Timing
- While rst=1: state=RUN, ret=RUN, stall_cnt=0, and every output =0 regardless of inputs. Reset applied mid-DMISS or mid-DRAIN returns to RUN immediately.
- Zero-cycle latency from inputs to control outputs: they take effect at the next rising edge of the controlled registers.
- A load-use hazard produces exactly one bubble. In the following cycle the load is in MEM, EX holds the bubble, lu=0, and ID advances.
- Freeze precedence: when any freeze is active (DMISS, DMiss in RUN/DRAIN, or HALTED), flush_IFID=0 and nop_IDEX=0. Stall takes precedence over nop in ID/EX.
- Halt_WB arriving while in DMISS is acted on in the first non-DMISS cycle, if ret=DRAIN.
- State and counter update on the rising clk edge only. hz_state reflects the registered state.

## Test plan
- **Load-use:** MemRead_EX=1, DstReg_EX=3, SrcReg2_ID=3, Src2Used_ID=1 → stall_PC=stall_IFID=nop_IDEX=1 for one cycle. Next cycle (MemRead_EX=0), all outputs 0; stall_cnt=1. Repeat with DstReg_EX=0 → no stall.
- **D-cache freeze:** DMiss high for 3 cycles in RUN → all five stalls =1 for 3 cycles and hz_state=1 for cycles 2–3. The cycle DMiss falls → RUN outputs; stall_cnt=3.
- **Branch under I-miss:** BranchTaken_ID=1 with IMiss=1 for 2 cycles → nop_IDEX=stall_PC=1, flush_IFID=0. Then IMiss=0 → flush_IFID=1, stall_PC=0.
- **Halt:** Halt_ID=1 → flush_IFID=stall_PC=1 and hz_state=2 next cycle. Halt_WB=1 three cycles later → hz_state=3, all stalls =1, stall_cnt frozen.
- **Reset mid-operation:** rst asserted in DMISS with DMiss=1 → hz_state=0, all outputs 0 and stall_cnt=0 asynchronously, before the next edge.
- **Saturation:** IMiss held for 70000 cycles → stall_cnt stops at 16'hFFFF and stays there.
